// File: rtl/core_input_rx_if.sv
// Write/replay bus between the realign stage, one core's input buffer and its round logic.
`ifndef BLK_OP_MSB
`define BLK_OP_MSB 3
`endif

interface core_input_rx_if #(
  parameter int WIDTH = 32
);
  logic                 wr_en;
  logic [3:0]           wr_addr;
  logic [WIDTH-1:0]     din;
  logic                 in_ctx;
  logic                 in_seq;
  logic [`BLK_OP_MSB:0] in_blk_op;
  logic                 set_input_ready;
  logic [3:0]           slot_full;
  logic                 rd_start;
  logic [1:0]           rd_slot;
  logic                 rd_busy;
  logic [WIDTH-1:0]     dout;
  logic                 dout_valid;
  logic [3:0]           dout_addr;
  logic [`BLK_OP_MSB:0] dout_blk_op;
  logic                 rd_done;
  logic                 err;

  modport slave (
    input  wr_en, wr_addr, din, in_ctx, in_seq, in_blk_op, set_input_ready,
    input  rd_start, rd_slot,
    output slot_full, rd_busy, dout, dout_valid, dout_addr, dout_blk_op, rd_done, err
  );

  modport master (
    output wr_en, wr_addr, din, in_ctx, in_seq, in_blk_op, set_input_ready,
    output rd_start, rd_slot,
    input  slot_full, rd_busy, dout, dout_valid, dout_addr, dout_blk_op, rd_done, err
  );
endinterface

// File: rtl/core_input_rx.sv
// Per-core 4-slot block buffer: accepts 16-word block writes per thread slot and
// replays a full slot, with its block-op, to the round logic on request.
`ifndef BLK_OP_MSB
`define BLK_OP_MSB 3
`endif

module core_input_rx #(
  parameter int WIDTH   = 32,
  parameter int N_SLOTS = 4
) (
  input logic            i_clk,
  input logic            i_rst,
  core_input_rx_if.slave i_rx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [WIDTH-1:0]     r_mem [64];
  logic [WIDTH-1:0]     r_dout;
  logic [`BLK_OP_MSB:0] r_blk_op [N_SLOTS];

  state_t               r_state;
  logic [N_SLOTS-1:0]   r_slot_full;
  logic [1:0]           r_slot;
  logic [3:0]           r_cnt;
  logic                 r_wrap;
  logic                 r_rd_busy;
  logic                 r_dout_valid;
  logic [3:0]           r_dout_addr;
  logic [`BLK_OP_MSB:0] r_dout_blk_op;
  logic                 r_rd_done;
  logic                 r_err;

  logic [1:0]           w_wr_slot;
  logic                 w_mem_wr;
  logic                 w_issue;
  logic [5:0]           w_rd_addr;
  logic [N_SLOTS-1:0]   w_clr_mask;
  logic [N_SLOTS-1:0]   w_set_mask;
  logic [N_SLOTS-1:0]   w_full_after_clr;

  assign w_wr_slot        = {i_rx.in_ctx, i_rx.in_seq};
  assign w_mem_wr         = i_rx.wr_en && !r_slot_full[w_wr_slot];
  assign w_issue          = (r_state == S_READ) && !r_wrap;
  assign w_rd_addr        = {r_slot, r_cnt};
  assign w_full_after_clr = r_slot_full & ~w_clr_mask;

  // The DONE clear is ordered before a same-cycle completion so the slot ends full.
  always_comb begin
    w_clr_mask = '0;
    w_set_mask = '0;
    if (r_state == S_DONE)    w_clr_mask[r_slot]    = 1'b1;
    if (i_rx.set_input_ready) w_set_mask[w_wr_slot] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_wr) r_mem[{w_wr_slot, i_rx.wr_addr}] <= i_rx.din;
    if (w_issue)  r_dout <= r_mem[w_rd_addr];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_slot_full   <= '0;
      r_slot        <= '0;
      r_cnt         <= '0;
      r_wrap        <= 1'b0;
      r_rd_busy     <= 1'b0;
      r_dout_valid  <= 1'b0;
      r_dout_addr   <= '0;
      r_dout_blk_op <= '0;
      r_rd_done     <= 1'b0;
      r_err         <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) r_blk_op[i] <= '0;
    end else begin
      r_dout_valid <= w_issue;
      if (w_issue) r_dout_addr <= r_cnt;
      r_rd_done   <= 1'b0;
      r_slot_full <= w_full_after_clr | w_set_mask;

      if (i_rx.wr_en && r_slot_full[w_wr_slot]) r_err <= 1'b1;
      if (i_rx.set_input_ready) begin
        if (w_full_after_clr[w_wr_slot]) r_err <= 1'b1;
        else                             r_blk_op[w_wr_slot] <= i_rx.in_blk_op;
      end

      case (r_state)
        S_IDLE: begin
          if (i_rx.rd_start) begin
            if (r_slot_full[i_rx.rd_slot]) begin
              r_slot        <= i_rx.rd_slot;
              r_cnt         <= '0;
              r_wrap        <= 1'b0;
              r_rd_busy     <= 1'b1;
              r_dout_blk_op <= r_blk_op[i_rx.rd_slot];
              r_state       <= S_READ;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_READ: begin
          // One extra READ cycle after the wrap lets the registered read drain.
          if (r_wrap) begin
            r_wrap    <= 1'b0;
            r_rd_done <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) r_wrap <= 1'b1;
          end
        end
        S_DONE: begin
          r_rd_busy <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign i_rx.slot_full   = r_slot_full;
  assign i_rx.rd_busy     = r_rd_busy;
  assign i_rx.dout        = r_dout;
  assign i_rx.dout_valid  = r_dout_valid;
  assign i_rx.dout_addr   = r_dout_addr;
  assign i_rx.dout_blk_op = r_dout_blk_op;
  assign i_rx.rd_done     = r_rd_done;
  assign i_rx.err         = r_err;

endmodule

// File: tb/tb_core_input_rx.sv
// Directed bench for core_input_rx: fill, replay, back-to-back, error and reset scenarios.
`ifndef BLK_OP_MSB
`define BLK_OP_MSB 3
`endif

module tb_core_input_rx;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  core_input_rx_if #(.WIDTH(32)) bus ();

  core_input_rx #(.WIDTH(32), .N_SLOTS(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_rx  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en           = 1'b0;
    bus.wr_addr         = '0;
    bus.din             = '0;
    bus.in_ctx          = 1'b0;
    bus.in_seq          = 1'b0;
    bus.in_blk_op       = '0;
    bus.set_input_ready = 1'b0;
    bus.rd_start        = 1'b0;
    bus.rd_slot         = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic write_block(input logic [1:0] slot, input logic [31:0] base);
    for (int a = 0; a < 16; a++) begin
      bus.wr_en                 = 1'b1;
      bus.wr_addr               = a[3:0];
      bus.din                   = base + a;
      {bus.in_ctx, bus.in_seq}  = slot;
      step();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic set_ready(input logic [1:0] slot, input logic [3:0] op);
    bus.set_input_ready      = 1'b1;
    {bus.in_ctx, bus.in_seq} = slot;
    bus.in_blk_op            = op;
    step();
    bus.set_input_ready      = 1'b0;
  endtask

  // Replay one slot and compare every cycle from rd_start to one cycle after rd_done.
  task automatic run_replay(input logic [1:0] slot, input logic [31:0] base, input logic [3:0] op,
                            input bit resurrect, input logic [3:0] new_op, input bit poke);
    logic [41:0] exp_w;
    logic [41:0] got_w;
    logic [2:0]  exp3;
    logic [2:0]  got3;
    bus.rd_start = 1'b1;
    bus.rd_slot  = slot;
    step();
    bus.rd_start = 1'b0;
    n_cmp++;
    if ({bus.rd_busy, bus.dout_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL replay%0d_start: busy,valid=%b expected 10", slot, {bus.rd_busy, bus.dout_valid});
    end
    step();
    for (int i = 0; i < 16; i++) begin
      if (poke && i == 3) begin
        bus.rd_start = 1'b1;
        bus.rd_slot  = slot ^ 2'd1;
      end
      if (poke && i == 4) bus.rd_start = 1'b0;
      exp_w = {1'b1, 4'(i), base + 32'(i), op, 1'b0};
      got_w = {bus.dout_valid, bus.dout_addr, bus.dout, bus.dout_blk_op, bus.rd_done};
      n_cmp++;
      if (got_w !== exp_w) begin
        n_bad++;
        $display("FAIL replay%0d_word%0d: valid/addr/data/op/done=%h expected %h", slot, i, got_w, exp_w);
      end
      step();
    end
    n_cmp++;
    if ({bus.rd_done, bus.dout_valid, bus.rd_busy} !== 3'b101) begin
      n_bad++;
      $display("FAIL replay%0d_done: done,valid,busy=%b expected 101", slot,
               {bus.rd_done, bus.dout_valid, bus.rd_busy});
    end
    if (resurrect) begin
      bus.set_input_ready      = 1'b1;
      {bus.in_ctx, bus.in_seq} = slot;
      bus.in_blk_op            = new_op;
    end
    step();
    bus.set_input_ready = 1'b0;
    exp3 = {2'b00, resurrect};
    got3 = {bus.rd_done, bus.rd_busy, bus.slot_full[slot]};
    n_cmp++;
    if (got3 !== exp3) begin
      n_bad++;
      $display("FAIL replay%0d_after: done,busy,full=%b expected %b", slot, got3, exp3);
    end
  endtask

  task automatic test_reset();
    bit seen;
    do_reset();
    n_cmp++;
    if ({bus.slot_full, bus.rd_busy, bus.dout_valid, bus.dout_addr, bus.rd_done, bus.err} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outputs: full/busy/valid/addr/done/err=%h expected 000",
               {bus.slot_full, bus.rd_busy, bus.dout_valid, bus.dout_addr, bus.rd_done, bus.err});
    end
    write_block(2'd1, 32'h0000_0100);
    set_ready(2'd1, 4'd1);
    bus.rd_start = 1'b1;
    bus.rd_slot  = 2'd1;
    step();
    bus.rd_start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    n_cmp++;
    if ({bus.dout_valid, bus.dout_addr, bus.dout} !== {1'b1, 4'd7, 32'h0000_0107}) begin
      n_bad++;
      $display("FAIL reset_word7: valid/addr/data=%h expected %h",
               {bus.dout_valid, bus.dout_addr, bus.dout}, {1'b1, 4'd7, 32'h0000_0107});
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.rd_busy, bus.dout_valid, bus.slot_full} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_mid_replay: busy,valid,full=%b expected 000000",
               {bus.rd_busy, bus.dout_valid, bus.slot_full});
    end
    step();
    step();
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.rd_done !== 1'b0 || bus.dout_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_no_done: activity after reset=%b expected 0", seen);
    end
  endtask

  task automatic test_basic();
    write_block(2'd2, 32'h0000_1000);
    set_ready(2'd2, 4'd3);
    n_cmp++;
    if (bus.slot_full !== 4'b0100) begin
      n_bad++;
      $display("FAIL basic_full: slot_full=%b expected 0100", bus.slot_full);
    end
    run_replay(2'd2, 32'h0000_1000, 4'd3, 1'b0, 4'd0, 1'b0);
    n_cmp++;
    if (bus.slot_full !== 4'b0000) begin
      n_bad++;
      $display("FAIL basic_cleared: slot_full=%b expected 0000", bus.slot_full);
    end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 4; s++) begin
      write_block(s[1:0], 32'h0000_2000 + 32'(s) * 32'h100);
      set_ready(s[1:0], 4'(s + 4));
    end
    n_cmp++;
    if (bus.slot_full !== 4'b1111) begin
      n_bad++;
      $display("FAIL b2b_full: slot_full=%b expected 1111", bus.slot_full);
    end
    run_replay(2'd3, 32'h0000_2300, 4'd7, 1'b0, 4'd0, 1'b0);
    run_replay(2'd0, 32'h0000_2000, 4'd4, 1'b0, 4'd0, 1'b0);
    run_replay(2'd1, 32'h0000_2100, 4'd5, 1'b0, 4'd0, 1'b0);
    run_replay(2'd2, 32'h0000_2200, 4'd6, 1'b0, 4'd0, 1'b0);
    n_cmp++;
    if (bus.slot_full !== 4'b0000 || bus.err !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_final: full,err=%b expected 00000", {bus.slot_full, bus.err});
    end
  endtask

  task automatic test_coincide();
    write_block(2'd0, 32'h0000_3000);
    set_ready(2'd0, 4'd1);
    run_replay(2'd0, 32'h0000_3000, 4'd1, 1'b1, 4'd9, 1'b0);
    n_cmp++;
    if ({bus.slot_full, bus.err} !== 5'b00010) begin
      n_bad++;
      $display("FAIL coincide_full: full,err=%b expected 00010", {bus.slot_full, bus.err});
    end
    run_replay(2'd0, 32'h0000_3000, 4'd9, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_busy_ignore();
    write_block(2'd0, 32'h0000_5000);
    set_ready(2'd0, 4'hA);
    run_replay(2'd0, 32'h0000_5000, 4'hA, 1'b0, 4'd0, 1'b1);
    n_cmp++;
    if (bus.err !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_ignore_err: err=%b expected 0", bus.err);
    end
  endtask

  task automatic test_write_full();
    write_block(2'd1, 32'h0000_4000);
    set_ready(2'd1, 4'd2);
    bus.wr_en                = 1'b1;
    bus.wr_addr              = 4'd5;
    bus.din                  = 32'h0000_DEAD;
    {bus.in_ctx, bus.in_seq} = 2'd1;
    step();
    bus.wr_en = 1'b0;
    n_cmp++;
    if (bus.err !== 1'b1) begin
      n_bad++;
      $display("FAIL write_full_err: err=%b expected 1", bus.err);
    end
    run_replay(2'd1, 32'h0000_4000, 4'd2, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_rd_empty();
    do_reset();
    bus.rd_start = 1'b1;
    bus.rd_slot  = 2'd0;
    step();
    bus.rd_start = 1'b0;
    n_cmp++;
    if ({bus.err, bus.rd_busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL rd_empty: err,busy=%b expected 10", {bus.err, bus.rd_busy});
    end
    step();
    n_cmp++;
    if (bus.dout_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_empty_valid: dout_valid=%b expected 0", bus.dout_valid);
    end
  endtask

  task automatic test_set_full();
    do_reset();
    write_block(2'd3, 32'h0000_6000);
    set_ready(2'd3, 4'd5);
    set_ready(2'd3, 4'd6);
    n_cmp++;
    if ({bus.slot_full, bus.err} !== 5'b10001) begin
      n_bad++;
      $display("FAIL set_full: full,err=%b expected 10001", {bus.slot_full, bus.err});
    end
    run_replay(2'd3, 32'h0000_6000, 4'd5, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_back_to_back();
    test_coincide();
    test_busy_ignore();
    test_write_full();
    test_rd_empty();
    test_set_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
